// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size encodings, op bit positions,
// FSM state encoding and the alignment check.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_SZ_BYTE = 2'b00;
  localparam logic [1:0] LSU_SZ_HALF = 2'b01;
  localparam logic [1:0] LSU_SZ_WORD = 2'b10;

  localparam int LSU_OP_STORE    = 3;
  localparam int LSU_OP_UNSIGNED = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_WR = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Illegal size (11) is folded in here so the top needs only one error term besides range.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) ||
           (size == LSU_SZ_HALF && lo[0]) ||
           (size == LSU_SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte-lane logic: extracts and extends load data, and merges store data into a
// read word for the read-modify-write path. Purely combinational.
module load_store_unit_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_sel,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (byte_sel)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = byte_sel[1] ? word[31:16] : word[15:0];

    case (size)
      LSU_SZ_BYTE: load_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      LSU_SZ_HALF: load_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      default:     load_data = word;
    endcase

    merged = word;
    if (size == LSU_SZ_BYTE) begin
      case (byte_sel)
        2'd0:    merged[7:0]   = wdata_lo[7:0];
        2'd1:    merged[15:8]  = wdata_lo[7:0];
        2'd2:    merged[23:16] = wdata_lo[7:0];
        default: merged[31:24] = wdata_lo[7:0];
      endcase
    end else if (size == LSU_SZ_HALF) begin
      if (byte_sel[1]) merged[31:16] = wdata_lo;
      else             merged[15:0]  = wdata_lo;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data_mem. Sub-word stores
// run as read-modify-write; every op ends with a one-cycle done pulse in RESP.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_dataOut,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken at a posedge where req=1 and ready=1; ready is high
  // only in IDLE, done pulses for one cycle in RESP, and err/rdata are valid with done.

  lsu_state_t  state;
  logic [29:0] word_q;
  logic [31:0] merge_q;

  logic        is_store;
  logic        is_unsigned;
  logic [1:0]  size;
  logic        out_of_range;
  logic        bad;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign is_store     = op[LSU_OP_STORE];
  assign is_unsigned  = op[LSU_OP_UNSIGNED];
  assign size         = op[1:0];
  assign out_of_range = {2'b00, addr[31:2]} >= $unsigned(DATA_MEM_SIZE);
  assign bad          = misaligned(size, addr[1:0]) | out_of_range;
  assign accept       = req & (state == ST_IDLE);

  assign ready     = (state == ST_IDLE);
  assign done      = (state == ST_RESP);
  assign dbg_state = state;

  load_store_unit_lane u_lane (
    .word        (mem_dataOut),
    .byte_sel    (addr[1:0]),
    .size        (size),
    .is_unsigned (is_unsigned),
    .wdata_lo    (wdata[15:0]),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Strobes are gated by rst so a reset in RMW_WR drops the pending write.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    if (!rst) begin
      if (accept && !bad) begin
        mem_address = {2'b00, addr[31:2]};
        if (is_store && size == LSU_SZ_WORD) begin
          mem_write     = 1'b1;
          mem_writeData = wdata;
        end else begin
          mem_read = 1'b1;
        end
      end else if (state == ST_RMW_WR) begin
        mem_write     = 1'b1;
        mem_address   = {2'b00, word_q};
        mem_writeData = merge_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      word_q  <= '0;
      merge_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            word_q <= addr[31:2];
            err    <= bad;
            state  <= ST_RESP;
            if (!bad) begin
              if (!is_store) begin
                rdata <= load_data;
              end else if (size != LSU_SZ_WORD) begin
                merge_q <= merged;
                state   <= ST_RMW_WR;
              end
            end
          end
        end
        ST_RMW_WR: state <= ST_RESP;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, per-cycle expected-output queue built
// from a behavioural model, directed cases with literal values and random traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, err, mem_write, mem_read;
  logic [31:0] rdata, mem_address, mem_writeData, mem_dataOut;
  logic [1:0]  dbg_state;

  typedef struct {
    logic        ready;
    logic        done;
    logic        err;
    logic        rd;
    logic        wr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [31:0] dmem    [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = 10'h0;
  logic [31:0] poke_val = 32'h0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] cur_rdata = 32'h0;
  logic        last_err = 1'b0;
  logic        check_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  load_store_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .op            (op),
    .addr          (addr),
    .wdata         (wdata),
    .ready         (ready),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .mem_dataOut   (mem_dataOut),
    .dbg_state     (dbg_state)
  );

  // data_mem: combinational read, write at posedge
  assign mem_dataOut = (mem_address < 32'd1024) ? dmem[mem_address[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en) dmem[poke_idx] <= poke_val;
    else if (mem_write && mem_address < 32'd1024) dmem[mem_address[9:0]] <= mem_writeData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: appends the expected outputs of every cycle of one op
  task automatic model_op(input logic st, input logic uns, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    cyc_t        c;
    logic        is_bad;
    logic [31:0] w, old, v, mask, nw;
    int          sh;
    w      = a >> 2;
    is_bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
             (w >= 32'd1024);
    old    = is_bad ? 32'h0 : ref_mem[w[9:0]];
    sh     = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask   = (sz == 2'd0) ? (32'hFF << sh) : (sz == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    v      = (old & mask) >> sh;
    if (!uns && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    nw     = (old & ~mask) | ((wd << sh) & mask);

    c.ready = 1'b1; c.done = 1'b0; c.err = 1'b0;
    c.rd = !is_bad && !(st && sz == 2'd2);
    c.wr = !is_bad && st && sz == 2'd2;
    c.maddr = w; c.mwdata = wd; c.rdata = 32'h0;
    exp_q.push_back(c);

    if (!is_bad && st) begin
      ref_mem[w[9:0]] = nw;
      if (sz != 2'd2) begin
        c.ready = 1'b0; c.rd = 1'b0; c.wr = 1'b1; c.mwdata = nw;
        exp_q.push_back(c);
      end
    end
    if (!is_bad && !st) model_rdata = v;

    c.ready = 1'b0; c.done = 1'b1; c.err = is_bad; c.rd = 1'b0; c.wr = 1'b0;
    c.rdata = model_rdata;
    exp_q.push_back(c);
  endtask

  // driver: called at posedge+1; returns just after the accepting posedge
  task automatic issue(input logic st, input logic uns, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic hold);
    logic was_ready;
    int   guard = 0;
    req = 1'b1; op = {st, uns, sz}; addr = a; wdata = wd;
    model_op(st, uns, sz, a, wd);
    do begin
      was_ready = ready;
      @(posedge clk); #1;
      guard++;
    end while (!was_ready && guard < 20);
    if (!was_ready) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx[9:0]; poke_val = val;
    ref_mem[idx] = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // scoreboard: per-cycle compare at negedge
  initial begin
    forever begin
      @(negedge clk);
      if (check_en && !rst) begin : cmp
        cyc_t e;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ready", 32'(ready), 32'(e.ready));
          chk("done", 32'(done), 32'(e.done));
          chk("mem_read", 32'(mem_read), 32'(e.rd));
          chk("mem_write", 32'(mem_write), 32'(e.wr));
          if (e.rd || e.wr) chk("mem_address", mem_address, e.maddr);
          if (e.wr) chk("mem_writeData", mem_writeData, e.mwdata);
          if (e.done) begin
            chk("err", 32'(err), 32'(e.err));
            cur_rdata = e.rdata;
            last_err  = err;
          end
        end else begin
          chk("idle_ready", 32'(ready), 32'd1);
          chk("idle_done", 32'(done), 32'd0);
          chk("idle_mem_read", 32'(mem_read), 32'd0);
          chk("idle_mem_write", 32'(mem_write), 32'd0);
        end
        chk("rdata", rdata, cur_rdata);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          mism;
    int          r;
    logic        hold;
    logic [31:0] a;

    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_writeData", mem_writeData, 32'h0);
    @(posedge clk); #1;
    check_en = 1'b1;

    // directed cases with hand-computed results
    poke(4, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
    wait_idle();
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    chk("lw_err", 32'(last_err), 32'd0);

    poke(4, 32'h8011_2233);
    issue(1'b0, 1'b0, 2'd0, 32'h13, 32'h0, 1'b0);
    wait_idle();
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    issue(1'b0, 1'b1, 2'd0, 32'h13, 32'h0, 1'b0);
    wait_idle();
    chk("lbu_rdata", rdata, 32'h0000_0080);

    poke(4, 32'h1122_3344);
    issue(1'b1, 1'b0, 2'd0, 32'h11, 32'h0000_00AA, 1'b0);
    wait_idle();
    chk("sb_mem4", dmem[4], 32'h1122_AA44);

    poke(4, 32'h1122_3344);
    issue(1'b1, 1'b0, 2'd1, 32'h12, 32'h0000_BEEF, 1'b1);
    issue(1'b0, 1'b1, 2'd1, 32'h12, 32'h0, 1'b0);
    wait_idle();
    chk("sh_mem4", dmem[4], 32'hBEEF_3344);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);

    issue(1'b1, 1'b0, 2'd2, 32'h14, 32'h5566_7788, 1'b0);
    wait_idle();
    chk("sw_mem5", dmem[5], 32'h5566_7788);

    poke(0, 32'hCAFE_F00D);
    issue(1'b0, 1'b0, 2'd2, 32'h02, 32'h0, 1'b0);
    wait_idle();
    chk("lw_mis_err", 32'(last_err), 32'd1);
    issue(1'b1, 1'b0, 2'd1, 32'h01, 32'h0000_1234, 1'b0);
    wait_idle();
    chk("sh_mis_err", 32'(last_err), 32'd1);
    issue(1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b0);
    wait_idle();
    chk("lw_range_err", 32'(last_err), 32'd1);
    chk("err_rdata_held", rdata, 32'h0000_BEEF);
    chk("err_mem0", dmem[0], 32'hCAFE_F00D);

    // reset while the RMW write is pending
    poke(4, 32'h1122_3344);
    check_en = 1'b0;
    req = 1'b1; op = 4'b1000; addr = 32'h11; wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rmw_busy_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmw_rst_ready", 32'(ready), 32'd1);
    chk("rmw_rst_done", 32'(done), 32'd0);
    chk("rmw_rst_rdata", rdata, 32'h0);
    chk("rmw_rst_mem4", dmem[4], 32'h1122_3344);
    exp_q.delete();
    model_rdata = 32'h0;
    cur_rdata   = 32'h0;
    check_en    = 1'b1;

    // random traffic
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else if (r == 8) a = ($urandom_range(1020, 1030) << 2) | $urandom_range(0, 3);
      else             a = $urandom;
      hold = (i != 299) && ($urandom_range(0, 1) == 1);
      issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();

    mism = 0;
    for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
